// File: rtl/vslc_pkg.sv
// Shared definitions for the VSLC timer bank: register select codes, timer
// modes, waveform phases, channel configuration payload and prescaler helper.
package vslc_pkg;

    localparam int unsigned WR_SEL_W = 3;
    localparam int unsigned PRESC_W  = 15;

    localparam logic [WR_SEL_W-1:0] WR_SEL_PA_HI = 3'd0;
    localparam logic [WR_SEL_W-1:0] WR_SEL_PA_LO = 3'd1;
    localparam logic [WR_SEL_W-1:0] WR_SEL_PB_HI = 3'd2;
    localparam logic [WR_SEL_W-1:0] WR_SEL_PB_LO = 3'd3;
    localparam logic [WR_SEL_W-1:0] WR_SEL_CFG   = 3'd4;

    localparam logic TIMER_MODE_CYCLE   = 1'b0;
    localparam logic TIMER_MODE_ONESHOT = 1'b1;

    typedef enum logic {
        PHASE_A = 1'b0,
        PHASE_B = 1'b1
    } phase_e;

    // CFG byte layout {3'b0, mode, div[3:0]}; only the low five bits are kept.
    typedef struct packed {
        logic       mode;
        logic [3:0] div;
    } timer_cfg_t;

    // Prescaler terminal value 2^div-1 (div=15 gives the full 15-bit range).
    function automatic logic [PRESC_W-1:0] presc_limit(input logic [3:0] div);
        return PRESC_W'((16'd1 << div) - 16'd1);
    endfunction

endpackage

// File: rtl/vslc_timer_channel.sv
// One timer channel: period/config registers, prescaler and phase A/B FSM.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   tick                global advance enable (0 freezes prescaler/counter)
//   wr_en               write strobe, already decoded for this channel
//   wr_sel, wr_data     register select and write byte
//   en_set, en_clr      enable request / disable request (clear wins)
//   timer_out           1 while in phase B
//   busy                channel enabled
//   done                one-cycle pulse at the end of phase B
module vslc_timer_channel
    import vslc_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          RETRIGGER = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                wr_en,
    input  logic [WR_SEL_W-1:0] wr_sel,
    input  logic [7:0]          wr_data,
    input  logic                en_set,
    input  logic                en_clr,
    output logic                timer_out,
    output logic                busy,
    output logic                done
);

    logic [WIDTH-1:0]   period_a_q, period_a_d;
    logic [WIDTH-1:0]   period_b_q, period_b_d;
    timer_cfg_t         cfg_q, cfg_d;
    logic               enabled_q, enabled_d;
    phase_e             phase_q, phase_d;
    logic [WIDTH-1:0]   counter_q, counter_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   active_period;

    // CFG bits [7:5] are reserved.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^wr_data[7:5];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_a_q <= WIDTH'(1);
            period_b_q <= WIDTH'(2);
            cfg_q      <= '{mode: TIMER_MODE_CYCLE, div: 4'd0};
            enabled_q  <= 1'b0;
            phase_q    <= PHASE_A;
            counter_q  <= '0;
            presc_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            period_a_q <= period_a_d;
            period_b_q <= period_b_d;
            cfg_q      <= cfg_d;
            enabled_q  <= enabled_d;
            phase_q    <= phase_d;
            counter_q  <= counter_d;
            presc_q    <= presc_d;
            done_q     <= done_d;
        end
    end

    // Next state: register writes, enable control, prescaler and phase advance
    always_comb begin
        period_a_d    = period_a_q;
        period_b_d    = period_b_q;
        cfg_d         = cfg_q;
        enabled_d     = enabled_q;
        phase_d       = phase_q;
        counter_d     = counter_q;
        presc_d       = presc_q;
        done_d        = 1'b0;
        active_period = (phase_q == PHASE_B) ? period_b_q : period_a_q;

        // HI writes land in bits [WIDTH-1:8]; the width cast drops excess
        // data bits and makes the write a no-op when WIDTH==8.
        if (wr_en) begin
            case (wr_sel)
                WR_SEL_PA_HI: period_a_d = WIDTH'({wr_data, period_a_q[7:0]});
                WR_SEL_PA_LO: period_a_d = (period_a_q & ~WIDTH'(8'hff)) | WIDTH'(wr_data);
                WR_SEL_PB_HI: period_b_d = WIDTH'({wr_data, period_b_q[7:0]});
                WR_SEL_PB_LO: period_b_d = (period_b_q & ~WIDTH'(8'hff)) | WIDTH'(wr_data);
                WR_SEL_CFG:   cfg_d      = timer_cfg_t'(wr_data[4:0]);
                default:      ;
            endcase
        end

        if (en_clr) begin
            enabled_d = 1'b0;
            phase_d   = PHASE_A;
            counter_d = '0;
            presc_d   = '0;
        end else if (en_set && (!enabled_q || RETRIGGER)) begin
            enabled_d = 1'b1;
            phase_d   = PHASE_A;
            counter_d = '0;
            presc_d   = '0;
        end else if (enabled_q && tick) begin
            if (presc_q == presc_limit(cfg_q.div)) begin
                presc_d = '0;
                // >= so a period lowered below the running count still ends the phase
                if (counter_q >= active_period) begin
                    counter_d = '0;
                    phase_d   = (phase_q == PHASE_A) ? PHASE_B : PHASE_A;
                    if (phase_q == PHASE_B) begin
                        done_d = 1'b1;
                        if (cfg_q.mode == TIMER_MODE_ONESHOT) begin
                            enabled_d = 1'b0;
                        end
                    end
                end else begin
                    counter_d = counter_q + WIDTH'(1);
                end
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    assign timer_out = (phase_q == PHASE_B);
    assign busy      = enabled_q;
    assign done      = done_q;

endmodule

// File: rtl/vslc_timer_bank.sv
// Multi-channel two-phase timer bank: write decoder plus NUM_CH channels.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   tick                global advance enable
//   wr_en/wr_ch/wr_sel/wr_data   byte-wide register write (bad channel ignored)
//   en_set, en_clr      per-channel enable / disable requests
//   timer_out, busy, done        per-channel waveform, enabled flag, end pulse
module vslc_timer_bank
    import vslc_pkg::*;
#(
    parameter  int unsigned NUM_CH    = 4,
    parameter  int unsigned WIDTH     = 16,
    parameter  int unsigned RETRIGGER = 0,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WR_SEL_W-1:0] wr_sel,
    input  logic [7:0]          wr_data,
    input  logic [NUM_CH-1:0]   en_set,
    input  logic [NUM_CH-1:0]   en_clr,
    output logic [NUM_CH-1:0]   timer_out,
    output logic [NUM_CH-1:0]   busy,
    output logic [NUM_CH-1:0]   done
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Channel indices >= NUM_CH never match, so such writes are dropped.
        logic ch_wr;
        assign ch_wr = wr_en && (wr_ch == CH_W'(i));

        vslc_timer_channel #(
            .WIDTH     (WIDTH),
            .RETRIGGER (RETRIGGER != 0)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .wr_en     (ch_wr),
            .wr_sel    (wr_sel),
            .wr_data   (wr_data),
            .en_set    (en_set[i]),
            .en_clr    (en_clr[i]),
            .timer_out (timer_out[i]),
            .busy      (busy[i]),
            .done      (done[i])
        );
    end

endmodule

// File: tb/tb_vslc_timer_bank.sv
// Testbench for vslc_timer_bank: one instance without and one with retrigger,
// sharing all inputs, each compared every cycle with an event-counting model.
module tb_vslc_timer_bank;

    localparam int NCH = 5;
    localparam int W   = 16;
    localparam int CHW = 3;

    logic           clk;
    logic           rst_n;
    logic           tick;
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [2:0]     wr_sel;
    logic [7:0]     wr_data;
    logic [NCH-1:0] en_set, en_clr;
    logic [NCH-1:0] out0, busy0, done0;
    logic [NCH-1:0] out1, busy1, done1;

    vslc_timer_bank #(.NUM_CH(NCH), .WIDTH(W), .RETRIGGER(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_sel(wr_sel), .wr_data(wr_data), .en_set(en_set), .en_clr(en_clr),
        .timer_out(out0), .busy(busy0), .done(done0));

    vslc_timer_bank #(.NUM_CH(NCH), .WIDTH(W), .RETRIGGER(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_sel(wr_sel), .wr_data(wr_data), .en_set(en_set), .en_clr(en_clr),
        .timer_out(out1), .busy(busy1), .done(done1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model, index [retrigger][channel]. A phase is measured in
    // events elapsed; an event is every 2^div-th tick since the last one.
    int m_pa[2][NCH], m_pb[2][NCH], m_div[2][NCH], m_mode[2][NCH];
    int m_on[2][NCH], m_in_b[2][NCH], m_evts[2][NCH], m_ticks[2][NCH], m_done[2][NCH];

    task automatic model_step();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NCH; c++) begin
                m_done[r][c] = 0;
                if (!rst_n) begin
                    m_pa[r][c] = 1; m_pb[r][c] = 2; m_div[r][c] = 0; m_mode[r][c] = 0;
                    m_on[r][c] = 0; m_in_b[r][c] = 0; m_evts[r][c] = 0; m_ticks[r][c] = 0;
                end else begin
                    if (en_clr[c]) begin
                        m_on[r][c] = 0; m_in_b[r][c] = 0; m_evts[r][c] = 0; m_ticks[r][c] = 0;
                    end else if (en_set[c] && (m_on[r][c] == 0 || r == 1)) begin
                        m_on[r][c] = 1; m_in_b[r][c] = 0; m_evts[r][c] = 0; m_ticks[r][c] = 0;
                    end else if (m_on[r][c] != 0 && tick) begin
                        if (m_ticks[r][c] + 1 == (1 << m_div[r][c])) begin
                            int lim;
                            m_ticks[r][c] = 0;
                            m_evts[r][c]++;
                            lim = (m_in_b[r][c] != 0) ? m_pb[r][c] : m_pa[r][c];
                            if (m_evts[r][c] > lim) begin
                                m_evts[r][c] = 0;
                                if (m_in_b[r][c] != 0) begin
                                    m_done[r][c] = 1;
                                    if (m_mode[r][c] != 0) m_on[r][c] = 0;
                                end
                                m_in_b[r][c] = 1 - m_in_b[r][c];
                            end
                        end else begin
                            m_ticks[r][c] = (m_ticks[r][c] + 1) % 32768;
                        end
                    end
                    if (wr_en && int'(wr_ch) == c) begin
                        case (int'(wr_sel))
                            0: m_pa[r][c] = (int'(wr_data) * 256 + m_pa[r][c] % 256) % (1 << W);
                            1: m_pa[r][c] = m_pa[r][c] - m_pa[r][c] % 256 + int'(wr_data);
                            2: m_pb[r][c] = (int'(wr_data) * 256 + m_pb[r][c] % 256) % (1 << W);
                            3: m_pb[r][c] = m_pb[r][c] - m_pb[r][c] % 256 + int'(wr_data);
                            4: begin
                                m_div[r][c]  = int'(wr_data) % 16;
                                m_mode[r][c] = (int'(wr_data) / 16) % 2;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        for (int r = 0; r < 2; r++) begin
            logic [NCH-1:0] eo, eb, ed, go, gb, gd;
            for (int c = 0; c < NCH; c++) begin
                eo[c] = (m_in_b[r][c] != 0);
                eb[c] = (m_on[r][c] != 0);
                ed[c] = (m_done[r][c] != 0);
            end
            go = (r == 0) ? out0 : out1;
            gb = (r == 0) ? busy0 : busy1;
            gd = (r == 0) ? done0 : done1;
            n_tests++;
            if (go !== eo || gb !== eb || gd !== ed) begin
                n_fail++;
                $display("FAIL model_r%0d cycle %0d: got out=%b busy=%b done=%b, want out=%b busy=%b done=%b",
                         r, cyc, go, gb, gd, eo, eb, ed);
            end
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_model();
    endtask

    task automatic check(input string name, input int idx, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d want %0d", name, idx, got, want);
        end
    endtask

    task automatic wr(input int ch, input int sel, input int data);
        wr_en = 1'b1; wr_ch = CHW'(ch); wr_sel = 3'(sel); wr_data = 8'(data);
        cycle();
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic       rst_n;
        logic       set0;
        logic       clr0;
        logic       tick;
        logic [2:0] exp;   // {timer_out[0], busy[0], done[0]} after the edge
    } vec_t;

    vec_t tbl[12];
    int   exp_t[7];
    int   rise, hi, dn, dn_at, nt;
    logic prev;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b010};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b010};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b110};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b110};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b110};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b011};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b010};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b110};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b110};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b110};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b000};
        exp_t   = '{4, 8, 12, 16, 20, 34, 38};

        rst_n = 1'b0; tick = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0;
        en_set = '0; en_clr = '0;
        cycle(); cycle();

        // Reset defaults and default waveform on channel 0
        for (int i = 0; i < 12; i++) begin
            rst_n = tbl[i].rst_n; tick = tbl[i].tick;
            en_set = {{(NCH-1){1'b0}}, tbl[i].set0};
            en_clr = {{(NCH-1){1'b0}}, tbl[i].clr0};
            cycle();
            check("tbl_row", i, int'({out0[0], busy0[0], done0[0]}), int'(tbl[i].exp));
        end
        en_set = '0; en_clr = '0; tick = 1'b1;

        // One-shot with a 16-bit phase A period on channel 1
        wr(1, 0, 8'h01); wr(1, 1, 8'h02); wr(1, 2, 8'h00); wr(1, 3, 8'h03); wr(1, 4, 8'h10);
        en_set = 5'b00010; cycle(); en_set = '0;
        rise = -1; hi = 0; dn = 0; dn_at = -1;
        for (int k = 1; k <= 300; k++) begin
            cycle();
            if (out0[1] && rise < 0) rise = k;
            if (out0[1]) hi++;
            if (done0[1]) begin dn++; dn_at = k; end
        end
        check("oneshot_rise", 0, rise, 259);
        check("oneshot_high", 0, hi, 4);
        check("oneshot_done_cnt", 0, dn, 1);
        check("oneshot_done_at", 0, dn_at, 263);
        check("oneshot_busy_end", 0, int'(busy0[1]), 0);

        // Prescaler div=2 with a 10-cycle tick gap on channel 2
        wr(2, 1, 0); wr(2, 3, 0); wr(2, 4, 8'h02);
        en_set = 5'b00100; cycle(); en_set = '0;
        prev = 1'b0; nt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick = (k >= 23 && k <= 32) ? 1'b0 : 1'b1;
            cycle();
            if (out0[2] != prev) begin
                if (nt < 7) check("presc_toggle", nt, k, exp_t[nt]);
                nt++;
                prev = out0[2];
            end
        end
        tick = 1'b1;
        check("presc_ntoggle", 0, nt, 7);
        en_clr = 5'b00100; cycle(); en_clr = '0;

        // Simultaneous set/clear: clear wins
        en_set = 5'b01000; en_clr = 5'b01000; cycle(); en_set = '0; en_clr = '0;
        check("setclr_busy_r0", 0, int'(busy0[3]), 0);
        check("setclr_busy_r1", 0, int'(busy1[3]), 0);

        // en_set mid phase B on channel 0 (periods 1/2)
        en_set = 5'b00001; cycle(); en_set = '0;
        cycle(); cycle(); cycle();
        en_set = 5'b00001; cycle(); en_set = '0;
        check("retrig_e4_r0_out", 0, int'(out0[0]), 1);
        check("retrig_e4_r1_out", 0, int'(out1[0]), 0);
        cycle();
        check("retrig_e5_r0_out", 0, int'(out0[0]), 0);
        check("retrig_e5_r0_done", 0, int'(done0[0]), 1);
        check("retrig_e5_r1_out", 0, int'(out1[0]), 0);
        cycle();
        check("retrig_e6_r1_out", 0, int'(out1[0]), 1);
        check("retrig_e6_r0_out", 0, int'(out0[0]), 0);
        en_clr = 5'b00001; cycle(); en_clr = '0;

        // Lowering period A below the running count on channel 1
        wr(1, 4, 8'h00); wr(1, 0, 8'h00); wr(1, 1, 200);
        en_set = 5'b00010; cycle(); en_set = '0;
        rise = -1; dn_at = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 51) begin
                wr_en = 1'b1; wr_ch = 3'd1; wr_sel = 3'd1; wr_data = 8'd10;
            end else begin
                wr_en = 1'b0;
            end
            cycle();
            if (out0[1] && rise < 0) rise = k;
            if (done0[1] && dn_at < 0) dn_at = k;
        end
        wr_en = 1'b0;
        check("live_rise", 0, rise, 52);
        check("live_done", 0, dn_at, 56);
        en_clr = 5'b00010; cycle(); en_clr = '0;

        // Ignored writes: channel out of range, select codes 5-7
        wr(5, 1, 8'h40); wr(0, 6, 8'hff); wr(0, 7, 8'h00); wr(0, 5, 8'h1f);
        en_set = 5'b00001; cycle(); en_set = '0;
        rise = -1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (out0[0] && rise < 0) rise = k;
        end
        check("badwr_rise", 0, rise, 2);

        // All channels running, then reset mid-operation
        wr(4, 1, 3); wr(4, 3, 1);
        en_set = 5'b11111; cycle(); en_set = '0;
        for (int k = 0; k < 60; k++) cycle();
        check("all_busy", 0, int'(busy0), 31);
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        check("reset_mid", 0, int'({out0, busy0, done0, out1, busy1, done1}), 0);

        // Randomised traffic against the model
        for (int n = 0; n < 2000; n++) begin
            tick = ($urandom_range(0, 7) != 0);
            en_set = '0; en_clr = '0;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 19) == 0) en_set[c] = 1'b1;
                if ($urandom_range(0, 39) == 0) en_clr[c] = 1'b1;
            end
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = CHW'($urandom_range(0, 7));
            wr_sel  = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom_range(0, 6));
            if (wr_sel == 3'd0 || wr_sel == 3'd2) wr_data = 8'($urandom_range(0, 1));
            if (wr_sel == 3'd4) begin
                wr_data = 8'($urandom_range(0, 2) + 16 * $urandom_range(0, 1));
                // divider changes only on idle channels, so the prescaler never overshoots
                if (int'(wr_ch) < NCH) begin
                    if (m_on[0][int'(wr_ch)] != 0 || m_on[1][int'(wr_ch)] != 0) wr_en = 1'b0;
                end
            end
            cycle();
        end
        wr_en = 1'b0; en_set = '0; en_clr = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
